// File: rtl/tbs_pkg.sv
// Shared definitions for the TBS link: receiver states, default line
// constants and the bit-period helper used by the UART-side blocks.
package tbs_pkg;

    localparam int DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int DEFAULT_BAUD_RATE = 115_200;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Rounded clocks-per-bit so odd ratios land on the nearest whole cycle.
    function automatic int bit_period(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// First-word-fallthrough byte FIFO: the head entry is always presented on
// head; overrun pulses for one cycle when a push is refused because it is full.
module rx_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             overrun
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    // The extra pointer bit distinguishes full from empty when the addresses match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            overrun <= push && full && !do_pop;
        end
    end

endmodule

// File: rtl/tbs_uart_rx.sv
// 8N1 UART receiver for the rebuilt TBS line: mid-bit 3-sample majority
// voting, stop-bit check, and a small FWFT FIFO towards the command logic.
module tbs_uart_rx
    import tbs_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       rs232_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int BIT   = bit_period(CLK_FREQ, BAUD_RATE);
    localparam int HALF  = BIT / 2;
    localparam int CNT_W = $clog2(BIT);

    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT - 1);

    rx_state_t        state;
    rx_state_t        state_next;
    logic             sync_d1;
    logic             sync_d2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_next;
    logic             samp0;
    logic             samp0_next;
    logic             samp1;
    logic             samp1_next;
    logic             frame_err_next;
    logic             push;
    logic             majority;
    logic             fifo_empty;
    logic             fifo_full;

    // Preset high so a reset release never looks like a start edge.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync_d1 <= 1'b1;
            sync_d2 <= 1'b1;
        end else begin
            sync_d1 <= rs232_in;
            sync_d2 <= sync_d1;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            samp0     <= 1'b1;
            samp1     <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            samp0     <= samp0_next;
            samp1     <= samp1_next;
            frame_err <= frame_err_next;
        end
    end

    // Third vote is the live synchronized sample taken at HALF+1.
    assign majority = (samp0 & samp1) | (samp0 & sync_d1) | (samp1 & sync_d1);

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        bit_idx_next   = bit_idx;
        shift_next     = shift_reg;
        samp0_next     = samp0;
        samp1_next     = samp1;
        frame_err_next = 1'b0;
        push           = 1'b0;

        case (state)
            IDLE: begin
                if (sync_d2 && !sync_d1) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START, DATA, STOP: begin
                cnt_next = cnt + 1'b1;
                if (cnt == CNT_S0) samp0_next = sync_d1;
                if (cnt == CNT_S1) samp1_next = sync_d1;
                if (cnt == CNT_DEC) begin
                    case (state)
                        START: if (majority) state_next = IDLE;
                        DATA:  shift_next = {majority, shift_reg[7:1]};
                        default: begin
                            // Leaving mid-stop-bit rearms in time for a back-to-back start.
                            if (majority) begin
                                push       = 1'b1;
                                state_next = IDLE;
                            end else begin
                                frame_err_next = 1'b1;
                                state_next     = WAIT_HIGH;
                            end
                        end
                    endcase
                end
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (state == START) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else if (state == DATA) begin
                        if (bit_idx == 3'd7) state_next = STOP;
                        else                 bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (sync_d1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign rx_valid = !fifo_empty;

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shift_reg),
        .pop       (rx_valid && rx_ready),
        .head      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overrun   (overrun)
    );

endmodule

// File: doc/tbs_uart_rx.md
# tbs_uart_rx

UART byte receiver that consumes the rebuilt NRZ stream from the TBS-to-UART converter and delivers framed bytes to the command logic. It detects the start bit, samples 8N1 frames at mid-bit with 3-sample majority voting, and checks the stop bit. Good bytes go into a small first-word-fallthrough FIFO with a valid/ready handshake. The block reports framing errors and FIFO overruns as single-cycle pulses.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency, Hz
- BAUD_RATE, 115200: line baud rate
- FIFO_DEPTH, 4: byte FIFO depth; power of two, ≥2
- clk_50M  input  1  system clock; the only clock
- rst_n  input  1  reset, asynchronous, active-low
- rs232_in  input  1  NRZ UART line, idle high
- rx_data  output  8  byte at FIFO head; valid only while rx_valid=1
- rx_valid  output  1  FIFO not empty
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: good byte dropped, FIFO full
- busy  output  1  receiver not in IDLE

## Operation
- BIT = round(CLK_FREQ/BAUD_RATE), which is 434 at the defaults. HALF = BIT/2, which is 217. Bit counter width is $clog2(BIT).
- rs232_in passes through a 2-FF synchronizer preset to 1. A falling edge is sync_d2=1 and sync_d1=0.
- States:
  - IDLE: on a falling edge, clear the bit counter and go to START.
  - START: take samples at counter values HALF-1, HALF and HALF+1, then decide by majority at HALF+1. Majority 1 is a false start; go to IDLE with no flags. Majority 0: continue.
  - At BIT-1, wrap the counter to 0 and go to DATA.
  - DATA: 8 bits, LSB first, each decided by majority at HALF+1 and shifted into the shift register. After bit 7 wraps, go to STOP.
  - STOP: decide by majority at HALF+1.
    - Majority 1: push the byte and go directly to IDLE. This rearms mid-stop-bit so back-to-back frames are received.
    - Majority 0: pulse frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE once the synchronized line is sampled 1.
- busy = (state != IDLE).
- FIFO behaviour:
  - Pointers are one bit wider than the address.
  - rx_valid = !empty. rx_data = mem[rd_ptr].
  - A pop happens when rx_valid & rx_ready.
  - A push into a full FIFO without a simultaneous pop is dropped and pulses overrun. FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both happen, no overrun.
  - Push and pop in the same cycle when empty: push only. rx_valid rises next cycle.
- Reset clears state, counters, shift register and both pointers.
  - Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset asserted mid-frame abandons the frame silently.

## Timing
- All outputs are registered or derived from registers. There is no combinational path from rs232_in to any output.
- Start detection occurs 2–3 cycles after the rs232_in falling edge.
- rx_valid rises 9·BIT+HALF+4 (±2) cycles after the start-bit falling edge, provided the FIFO was empty. That is ≈4127 cycles at the defaults.
- frame_err and overrun are high for exactly one cycle, aligned with the stop-bit decision cycle +1.
- A pop takes effect on the clock edge. The next entry, or rx_valid=0, is visible the following cycle.
- rx_data is stable while rx_valid=1 and rx_ready=0.
- Minimum start-bit low width for acceptance is HALF+2 cycles. Shorter glitches are rejected.

## Structure
- Package tbs_pkg holds:
  - the state enum: IDLE, START, DATA, STOP, WAIT_HIGH;
  - a bit-period function computing round(CLK_FREQ/BAUD_RATE);
  - default baud and clock constants, shared with the TBS-to-UART converter.
- Sub-module rx_byte_fifo: a parameterized FWFT FIFO with push, pop, full, empty and head data. The FSM, sampler and synchronizer stay in tbs_uart_rx.

## Test plan
- Clean frame 0x55, rx_ready=1 → one rx_valid cycle with rx_data=0x55. busy returns to 0. No flags.
- 100-cycle low glitch on the idle line → no push, no flags. busy is high at most ~220 cycles.
- Frame 0xA3 with stop bit driven low → frame_err pulses once and nothing is pushed. The next clean 0x3C after the line returns high is received correctly.
- Five back-to-back frames 0x01–0x05, rx_ready=0 → FIFO holds 0x01–0x04 in order and overrun pulses once on 0x05.
  - Then raise rx_ready: 0x01–0x04 drain one per cycle, then rx_valid=0.
- FIFO full with rx_ready=1 held exactly at the push cycle → no overrun, and the new byte appears last in order.
- Assert rst_n=0 during bit 4 of a frame → all outputs go to reset values immediately. After release, the trailing bits of the abandoned frame generate no output, and the next clean frame 0xC7 is received.
